uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Transmit scheduler that shares one UART transmitter between two requesters: an echo path that returns every received byte, and a banner generator that sends a fixed 20-byte string after a period of receive silence. It sits between the UART receiver (`rdsig`/`rxdata`) and the UART transmitter (`wrsig`/`dataout`). It replaces combinational output muxing with a registered, paced, lossless-where-possible byte stream.

## Interface
- `BYTE_CYCLES`, default 255: clock cycles reserved per transmitted byte. Must be ≥ transmitter frame time. Range 2..65535.
- `IDLE_CYCLES`, default 262144: cycles of receive silence before a banner is requested. Range 2..2^20.
- `FIFO_DEPTH`, default 4: echo FIFO entries. Must be a power of two, ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rdsig`  in  1  one-cycle pulse: `rxdata` holds a valid received byte.
- `rxdata`  in  8  received byte.
- `wrsig`  out  1  one-cycle pulse: transmitter starts sending `dataout`.
- `dataout`  out  8  byte to transmit. Registered and stable from the `wrsig` cycle until the next `wrsig`.
- `busy`  out  1  high while a byte slot is running or a banner is in progress.
- `ovf`  out  1  sticky: an echo byte was dropped because the FIFO was full. Cleared only by reset.

## Operation
- Reset values: `wrsig`=0, `dataout`=0, `busy`=0, `ovf`=0. The FIFO is empty, the idle counter is 0, the banner index is 0, and the state is IDLE.
- Echo FIFO:
  - `rdsig`=1 pushes `rxdata`.
  - When full, the push is dropped and `ovf` is set.
  - If a pop and a push occur in the same cycle while full, the push is accepted and `ovf` is not set.
- Idle counter:
  - Cleared on `rdsig`, and cleared while the FIFO is non-empty.
  - Otherwise it increments, saturating at `IDLE_CYCLES-1`.
  - At `IDLE_CYCLES-1`, with the state IDLE, a banner is started.
  - The counter clears when a banner starts or ends.
- State machine:
  - IDLE:
    - FIFO non-empty → ECHO.
    - Banner trigger → BANNER.
    - Echo wins if both occur in the same cycle.
  - ECHO: pop the head, drive `dataout`, pulse `wrsig`, load the slot counter with `BYTE_CYCLES-1` → GAP.
  - BANNER: drive `dataout` = ROM[index], pulse `wrsig`, load the slot counter → GAP.
  - GAP: the slot counter decrements. When it reaches 0:
    - FIFO non-empty → ECHO, and the banner index resets to 0 (banner aborted).
    - Else, banner active and index < 19 → index+1, BANNER.
    - Else → IDLE; the banner ends and the index resets to 0.
- Banner ROM, indices 0..19: "Hello ALINX AN3485", then 0x0A, then 0x0D.
- An aborted banner is never resumed. It restarts from index 0 only after another full `IDLE_CYCLES` of silence.
- `busy` = state ≠ IDLE.

## Timing
- Echo latency: `rdsig` in cycle t, with the block IDLE and the FIFO empty → `wrsig` in cycle t+2, with `dataout`=`rxdata`(t).
- Pacing:
  - Consecutive `wrsig` pulses are exactly `BYTE_CYCLES` cycles apart when work is pending, including at the GAP→ECHO/BANNER transition.
  - They are never closer together.
- Banner duration, if uninterrupted: 20 pulses spanning 19×`BYTE_CYCLES`+1 cycles.
- A reset assertion mid-slot or mid-banner returns all outputs to their reset values immediately (asynchronously). The FIFO contents are lost.
- `wrsig` is never high for two consecutive cycles.

## Structure
- Package `uart_pkg`:
  - state enum (IDLE, ECHO, BANNER, GAP)
  - `BANNER_LEN`=20
  - banner ROM constant array
  - byte typedef
- Sub-module `uart_echo_fifo`: a synchronous FIFO with parameter `DEPTH`, and signals `push`, `din`, `pop`, `dout`, `empty`, `full`, `drop`.
  - `dout` is show-ahead.
  - `drop` is a one-cycle pulse, used to set `ovf`.
- The scheduler holds the FSM, the slot counter (16 bits), the idle counter (20 bits), and the banner index (5 bits).

## Test plan
- Single echo: reset, then `rdsig` with 0x41 at cycle 10 → `wrsig` at cycle 12 with `dataout`=0x41, and `busy` high for `BYTE_CYCLES`. The banner must not fire before cycle 12+`BYTE_CYCLES`+`IDLE_CYCLES`.
- Burst overflow (`BYTE_CYCLES`=8, `FIFO_DEPTH`=4): 6 `rdsig` pulses, one per cycle, with 0x01..0x06.
  - Bytes 0x01..0x05 are echoed 8 cycles apart: the first is popped at once, four are queued.
  - 0x06 is dropped and `ovf`=1 stays set.
- Banner (`IDLE_CYCLES`=16, `BYTE_CYCLES`=4): no input after reset → 20 pulses, 4 cycles apart, carrying 0x48 0x65 … 0x0A 0x0D. `busy` then falls, and the next banner begins 16 idle cycles later.
- Abort: `rdsig` with 0x5A during banner byte 5's slot → byte 6 is not sent, the next pulse is 0x5A on the slot boundary, and the next banner restarts at 0x48.
- Reset mid-banner: `rst_n` low during GAP → `wrsig`/`dataout`/`busy`/`ovf` are 0 in the same cycle. After release, the FIFO is empty and there is no stray pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ECHO   = 2'd1,
        ST_BANNER = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam int BANNER_LEN = 20;

    // "Hello ALINX AN3485" followed by LF, CR
    localparam byte_t BANNER_ROM [BANNER_LEN] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h41, 8'h4C, 8'h49, 8'h4E,
        8'h58, 8'h20, 8'h41, 8'h4E, 8'h33, 8'h34, 8'h38, 8'h35, 8'h0A, 8'h0D
    };

endpackage

// File: rtl/uart_tx_sched_if.sv
// Receiver-side and transmitter-side signals of the transmit scheduler.
interface uart_tx_sched_if;
    import uart_pkg::*;

    logic  rdsig;
    byte_t rxdata;
    logic  wrsig;
    byte_t dataout;
    logic  busy;
    logic  ovf;

    modport master (output rdsig, output rxdata, input wrsig, input dataout, input busy, input ovf);
    modport slave  (input rdsig, input rxdata, output wrsig, output dataout, output busy, output ovf);

endinterface

// File: rtl/uart_echo_fifo.sv
// Small show-ahead FIFO buffering received bytes awaiting echo.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  byte_t din,
    input  logic  pop,
    output byte_t dout,
    output logic  empty,
    output logic  full,
    output logic  drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    byte_t       mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        pop_ok_s;
    logic        push_ok_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign drop      = push && full && !pop_ok_s;
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between a byte echo path and an idle-time banner,
// pacing every transmitted byte into a fixed-length slot.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int BYTE_CYCLES = 255,
    parameter int IDLE_CYCLES = 262144,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_sched_if.slave  bus
);

    localparam logic [15:0] SLOT_LOAD = 16'(BYTE_CYCLES - 1);
    localparam logic [19:0] IDLE_MAX  = 20'(IDLE_CYCLES - 1);
    localparam logic [4:0]  LAST_IDX  = 5'(BANNER_LEN - 1);

    state_t      state_r;
    state_t      state_nx_s;
    logic [15:0] slot_r;
    logic [19:0] idle_cnt_r;
    logic [4:0]  idx_r;
    logic [4:0]  idx_nx_s;
    logic        banner_r;
    logic        banner_nx_s;
    logic        fire_echo_s;
    logic        fire_banner_s;
    logic        fire_s;
    logic        idle_clr_s;
    byte_t       tx_byte_s;

    byte_t       fifo_dout_s;
    logic        fifo_empty_s;
    logic        fifo_full_s;
    logic        fifo_drop_s;

    logic        wrsig_r;
    byte_t       dataout_r;
    logic        busy_r;
    logic        ovf_r;

    uart_echo_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.rdsig),
        .din   (bus.rxdata),
        .pop   (fire_echo_s),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .drop  (fifo_drop_s)
    );

    // Next-state decode; a "fire" launches a byte and opens a new slot.
    always_comb begin
        state_nx_s    = state_r;
        idx_nx_s      = idx_r;
        banner_nx_s   = banner_r;
        fire_echo_s   = 1'b0;
        fire_banner_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    fire_echo_s = 1'b1;
                    state_nx_s  = ST_ECHO;
                end else if (idle_cnt_r == IDLE_MAX) begin
                    fire_banner_s = 1'b1;
                    banner_nx_s   = 1'b1;
                    idx_nx_s      = 5'd0;
                    state_nx_s    = ST_BANNER;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ECHO, ST_BANNER: begin
                state_nx_s = ST_GAP;
            end
            ST_GAP: begin
                if (slot_r != 16'd0) begin
                    state_nx_s = ST_GAP;
                end else if (!fifo_empty_s) begin
                    // Pending echo preempts the banner; it is not resumed.
                    fire_echo_s = 1'b1;
                    banner_nx_s = 1'b0;
                    idx_nx_s    = 5'd0;
                    state_nx_s  = ST_ECHO;
                end else if (banner_r && (idx_r < LAST_IDX)) begin
                    fire_banner_s = 1'b1;
                    idx_nx_s      = idx_r + 5'd1;
                    state_nx_s    = ST_BANNER;
                end else begin
                    banner_nx_s = 1'b0;
                    idx_nx_s    = 5'd0;
                    state_nx_s  = ST_IDLE;
                end
            end
            default: begin
                state_nx_s  = ST_IDLE;
                banner_nx_s = 1'b0;
                idx_nx_s    = 5'd0;
            end
        endcase
    end

    // Silence is measured only while the transmitter is quiet and nothing is queued.
    assign fire_s     = fire_echo_s || fire_banner_s;
    assign tx_byte_s  = fire_echo_s ? fifo_dout_s : BANNER_ROM[idx_nx_s];
    assign idle_clr_s = bus.rdsig || !fifo_empty_s || (state_r != ST_IDLE) || fire_banner_s;

    // FSM state, banner progress and slot timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            idx_r    <= 5'd0;
            banner_r <= 1'b0;
            slot_r   <= 16'd0;
        end else begin
            state_r  <= state_nx_s;
            idx_r    <= idx_nx_s;
            banner_r <= banner_nx_s;
            if (fire_s) begin
                slot_r <= SLOT_LOAD;
            end else if (slot_r != 16'd0) begin
                slot_r <= slot_r - 16'd1;
            end else begin
                slot_r <= slot_r;
            end
        end
    end

    // Saturating receive-silence counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= 20'd0;
        end else if (idle_clr_s) begin
            idle_cnt_r <= 20'd0;
        end else if (idle_cnt_r != IDLE_MAX) begin
            idle_cnt_r <= idle_cnt_r + 20'd1;
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // Registered transmitter-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrsig_r   <= 1'b0;
            dataout_r <= 8'h00;
            busy_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            wrsig_r <= fire_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            if (fire_s) begin
                dataout_r <= tx_byte_s;
            end
            if (fifo_drop_s && fifo_full_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign bus.wrsig   = wrsig_r;
    assign bus.dataout = dataout_r;
    assign bus.busy    = busy_r;
    assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: every transmitted byte is matched against
// a hand-computed (byte, cycle) expectation.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int BC = 8;
    localparam int IC = 16;
    localparam int FD = 4;

    localparam byte_t EXP_BANNER [20] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h41, 8'h4C, 8'h49, 8'h4E,
        8'h58, 8'h20, 8'h41, 8'h4E, 8'h33, 8'h34, 8'h38, 8'h35, 8'h0A, 8'h0D
    };

    typedef struct {
        byte_t data;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q [$];
    logic prev_wr = 1'b0;

    uart_tx_sched_if bus ();

    uart_tx_sched #(
        .BYTE_CYCLES (BC),
        .IDLE_CYCLES (IC),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_byte(input byte_t d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic expect_banner(input int start, input int count);
        for (int i = 0; i < count; i++) begin
            expect_byte(EXP_BANNER[i], start + i * BC);
        end
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input byte_t d, input int c);
        at_cycle(c);
        bus.rdsig  = 1'b1;
        bus.rxdata = d;
        at_cycle(c + 1);
        bus.rdsig  = 1'b0;
    endtask

    // Monitor: every wrsig pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (bus.wrsig === 1'b1) begin
            check("wrsig_gap", int'(prev_wr), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: got 0x%0h at cycle %0d, required no pulse", bus.dataout, cyc);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", int'(bus.dataout), int'(e.data));
                check("tx_cycle", cyc, e.cyc);
            end
        end
        prev_wr = bus.wrsig;
    end

    initial begin
        rst_n      = 1'b0;
        bus.rdsig  = 1'b0;
        bus.rxdata = 8'h00;

        at_cycle(1);
        check("rst_wrsig", int'(bus.wrsig), 0);
        check("rst_dataout", int'(bus.dataout), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ovf", int'(bus.ovf), 0);
        at_cycle(3);
        @(negedge clk);
        rst_n = 1'b1;

        // Single echo, then a full banner, then a banner aborted after byte 5.
        expect_byte(8'h41, 12);
        expect_banner(36, 20);
        expect_banner(212, 6);
        expect_byte(8'h5A, 260);

        send_rx(8'h41, 10);
        check("echo_busy_before", int'(bus.busy), 0);
        at_cycle(12);
        check("echo_busy_start", int'(bus.busy), 1);
        at_cycle(19);
        check("echo_busy_end", int'(bus.busy), 1);
        at_cycle(20);
        check("echo_busy_fall", int'(bus.busy), 0);
        at_cycle(25);
        check("echo_dataout_hold", int'(bus.dataout), 8'h41);
        at_cycle(195);
        check("banner_busy_last", int'(bus.busy), 1);
        at_cycle(196);
        check("banner_busy_fall", int'(bus.busy), 0);

        send_rx(8'h5A, 254);

        // Burst of six: five echoed one slot apart, the sixth dropped.
        at_cycle(268);
        check("ovf_before_burst", int'(bus.ovf), 0);
        for (int i = 0; i < 5; i++) begin
            expect_byte(byte_t'(i + 1), 272 + i * BC);
        end
        expect_banner(328, 3);
        for (int i = 0; i < 6; i++) begin
            send_rx(byte_t'(i + 1), 270 + i);
        end
        check("ovf_after_drop", int'(bus.ovf), 1);
        at_cycle(340);
        check("ovf_sticky", int'(bus.ovf), 1);

        // Asynchronous reset during a banner gap.
        at_cycle(347);
        rst_n = 1'b0;
        #1;
        check("arst_wrsig", int'(bus.wrsig), 0);
        check("arst_dataout", int'(bus.dataout), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_ovf", int'(bus.ovf), 0);
        at_cycle(349);
        @(negedge clk);
        rst_n = 1'b1;

        expect_byte(8'h7E, 357);
        expect_banner(381, 3);
        at_cycle(352);
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_ovf", int'(bus.ovf), 0);
        send_rx(8'h7E, 355);

        at_cycle(400);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
